hash_pe_req_arbiter: RTL and testbench
======================================

# hash_pe_req_arbiter

Round-robin arbiter that shares one hash PE input port among `NUM_REQ` serialized request streams, one per upstream request serializer. It sits between the serializers of the pre-hash-PE scheduler and a single hash PE. It grants with a configurable burst lock, registers the winning request into a single output stage, and enforces a delimiter barrier so a block boundary reaches the PE exactly once, after every requester has finished the block.

## Interface
- `NUM_REQ`, 4: number of requesters; must be ≥1.
- `NUM_REQ_LOG2`, 2: clog2 of `NUM_REQ`; minimum 1.
- `AW`, `` `ADDR_WIDTH ``: address width.
- `HW`, `` `HASH_BITS-`NUM_HASH_PE_LOG2 ``: hash value width.
- `clk`  in  1  clock. One clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cfg_max_burst`  in  4  maximum consecutive beats per grant. A value of 0 is treated as 1. Sampled only when a new grant is made.
- `req_valid`  in  NUM_REQ  per-requester valid.
- `req_addr`  in  NUM_REQ*AW  flattened addresses; requester i is at `[i*AW+:AW]`.
- `req_hash_value`  in  NUM_REQ*HW  flattened hash values.
- `req_delim`  in  NUM_REQ  per-requester end-of-block flag.
- `req_ready`  out  NUM_REQ  one-hot or zero.
- `out_valid`  out  1  registered.
- `out_addr`  out  AW  registered.
- `out_hash_value`  out  HW  registered.
- `out_delim`  out  1  registered; asserted only on the barrier-closing beat.
- `out_ready`  in  1  PE accepts.
- `barrier_mask`  out  NUM_REQ  requesters that have already delivered their delim beat in the current block.

## Operation
- **Load enable:** `load = !out_valid || out_ready`. The output register is a single stage with no bubble at full throughput.
- **Eligibility:** `elig[i] = req_valid[i] && !barrier_mask[i]`.
- **Arbitration states:**
  - **IDLE** (no lock): round-robin pick. Winner is the first eligible requester at or after `rr_ptr`, with wrap-around.
  - **LOCKED(g)**: `g` keeps the grant while `elig[g]`, `burst_cnt < burst_lim`, and its previous accepted beat was not a delim.
  - Lock is released, returning to IDLE, when any of those conditions fails. The new winner is chosen combinationally in the same cycle; there is no idle cycle.
- **Handshake:** `req_ready[w] = load && (winner w exists)`. A transfer on requester w is `req_valid[w] && req_ready[w]`. On a transfer, the output register loads w's addr, hash value and delim-derived flag, and `out_valid` becomes 1. When `load` is true and there is no winner, `out_valid` becomes 0.
- **Burst counter:**
  - On a fresh grant: `burst_lim = max(cfg_max_burst, 1)` and `burst_cnt = 1`.
  - Each further locked transfer: `burst_cnt` increments by 1.
  - `burst_cnt` width is 5 bits and never exceeds 15.
- **Round-robin pointer:** on lock release, `rr_ptr = (g+1) mod NUM_REQ`. Wrap is explicit; `NUM_REQ` need not be a power of 2.
- **Delim barrier:**
  - A transfer with `req_delim[w]=1` sets `barrier_mask[w]`, which masks w and releases the lock.
  - If that transfer makes the mask all-ones, the loaded `out_delim = 1` and `barrier_mask` clears to 0 in the same cycle. Otherwise the loaded `out_delim = 0`.
  - Beats from non-masked requesters keep flowing while others wait at the barrier.
  - With `NUM_REQ=1`, every delim beat passes with `out_delim=1`.
- **Simultaneous events:** a delim transfer and a mask clear happen in the same cycle; the clear wins and the mask is 0 next cycle. A `cfg_max_burst` change during a lock takes effect at the next grant.

## Timing
- **Reset values** (asynchronous, immediate): `out_valid=0`, `out_addr=0`, `out_hash_value=0`, `out_delim=0`, `barrier_mask=0`, `rr_ptr=0`, state IDLE, `burst_cnt=0`. `req_ready` is 0 during reset.
- **Latency:** a beat transferred in cycle N is presented on `out_*` in cycle N+1.
- **Throughput:** one beat per cycle when `out_ready=1`.
- **Backpressure:** when `out_ready=0` and `out_valid=1`, all `req_ready=0` and the output is held stable.
- **Reset mid-operation:** any in-flight output beat and a partial barrier are discarded. Upstream re-issues after reset.
- **`req_ready` path:** combinational from `req_valid`, `req_delim` state and `out_ready`. It must not depend on `req_*` data fields.

## Test plan
- **Round-robin rotation:** `NUM_REQ=4`, `cfg_max_burst=1`, all requesters valid continuously, `out_ready=1` -> output sources follow 0,1,2,3,0,… one beat per cycle; first `out_valid` one cycle after reset release plus first transfer.
- **Burst lock:** `cfg_max_burst=3`, requesters 0 and 2 valid -> output order is 0,0,0,2,2,2,0,…. With `cfg_max_burst=0` the order is 0,2,0,2.
- **Backpressure:** `out_ready` low for 5 cycles mid-stream -> `out_*` held constant and `req_ready=0`. On release, no beat is lost or duplicated; beat count in equals beat count out.
- **Delim barrier:** requester 1 sends a delim at beat 2 while the others send 10 beats each before their delim -> requester 1 is stalled with `barrier_mask=4'b0010`. Exactly one `out_delim=1` appears, on the last delim transferred, and `barrier_mask` is 0 the cycle after.
- **Wrap and idle gaps:** only requester 3 valid, then only requester 0 -> each is granted with no dead cycle; `rr_ptr` wraps 3→0.
- **Async reset mid-barrier:** assert `rst_n=0` between clock edges with mask 4'b0110 and `out_valid=1` -> `out_valid` and `barrier_mask` go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hash_pe_req_arbiter_if.sv
// Request-side and PE-side handshake bundle for the hash PE request arbiter.
// master = serializers + PE (testbench side), slave = the arbiter.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef HASH_BITS
`define HASH_BITS 32
`endif
`ifndef NUM_HASH_PE_LOG2
`define NUM_HASH_PE_LOG2 2
`endif

interface hash_pe_req_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int AW      = `ADDR_WIDTH,
  parameter int HW      = `HASH_BITS - `NUM_HASH_PE_LOG2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*HW-1:0] req_hash_value;
  logic [NUM_REQ-1:0]    req_delim;
  logic [NUM_REQ-1:0]    req_ready;

  logic                  out_valid;
  logic [AW-1:0]         out_addr;
  logic [HW-1:0]         out_hash_value;
  logic                  out_delim;
  logic                  out_ready;

  modport master (
    output req_valid, req_addr, req_hash_value, req_delim, out_ready,
    input  req_ready, out_valid, out_addr, out_hash_value, out_delim
  );

  modport slave (
    input  req_valid, req_addr, req_hash_value, req_delim, out_ready,
    output req_ready, out_valid, out_addr, out_hash_value, out_delim
  );
endinterface

// File: rtl/hash_pe_req_arbiter.sv
// Round-robin arbiter with burst lock and block-delimiter barrier feeding one
// hash PE through a single registered output stage.
//
// state     | meaning
// ST_IDLE   | no lock; next grant is a round-robin pick starting at rr_ptr
// ST_LOCKED | grant holds the lock while eligible, under burst_lim, no delim
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef HASH_BITS
`define HASH_BITS 32
`endif
`ifndef NUM_HASH_PE_LOG2
`define NUM_HASH_PE_LOG2 2
`endif

module hash_pe_req_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int NUM_REQ_LOG2 = 2,
  parameter int AW           = `ADDR_WIDTH,
  parameter int HW           = `HASH_BITS - `NUM_HASH_PE_LOG2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         cfg_max_burst,
  hash_pe_req_arbiter_if.slave bus,
  output logic [NUM_REQ-1:0] barrier_mask
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]              state;
  logic [NUM_REQ_LOG2-1:0] grant;
  logic [NUM_REQ_LOG2-1:0] rr_ptr;
  logic [4:0]              burst_cnt;
  logic [3:0]              burst_lim;
  logic                    last_delim;

  logic                    load;
  logic                    hold;
  logic                    found;
  logic                    xfer;
  logic                    delim_w;
  logic                    close;
  logic [NUM_REQ-1:0]      elig;
  logic [NUM_REQ-1:0]      win_oh;
  logic [NUM_REQ-1:0]      mask_next;
  logic [NUM_REQ_LOG2-1:0] winner;
  logic [NUM_REQ_LOG2-1:0] grant_next;
  logic [NUM_REQ_LOG2-1:0] base;
  logic [NUM_REQ_LOG2-1:0] idx;
  logic [NUM_REQ_LOG2:0]   sum;
  logic [NUM_REQ_LOG2:0]   grant_inc;
  logic [AW-1:0]           addr_sel;
  logic [HW-1:0]           hash_sel;
  logic [3:0]              lim_fresh;

  assign load      = !bus.out_valid || bus.out_ready;
  assign elig      = bus.req_valid & ~barrier_mask;
  assign lim_fresh = (cfg_max_burst == 4'd0) ? 4'd1 : cfg_max_burst;

  // Explicit wrap so NUM_REQ need not be a power of two.
  always_comb begin
    grant_inc  = {1'b0, grant} + {{NUM_REQ_LOG2{1'b0}}, 1'b1};
    grant_next = grant_inc[NUM_REQ_LOG2-1:0];
    if (grant_inc >= (NUM_REQ_LOG2+1)'(NUM_REQ)) grant_next = '0;
  end

  assign hold = (state == ST_LOCKED) && elig[grant] &&
                (burst_cnt < {1'b0, burst_lim}) && !last_delim;

  // On release the search starts just past the old owner, in the same cycle.
  assign base = (state == ST_LOCKED) ? grant_next : rr_ptr;

  always_comb begin
    winner = grant;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    if (hold) begin
      found = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        sum = {1'b0, base} + (NUM_REQ_LOG2+1)'(k);
        if (sum >= (NUM_REQ_LOG2+1)'(NUM_REQ))
          sum = sum - (NUM_REQ_LOG2+1)'(NUM_REQ);
        idx = sum[NUM_REQ_LOG2-1:0];
        if (!found && elig[idx]) begin
          found  = 1'b1;
          winner = idx;
        end
      end
    end
  end

  always_comb begin
    win_oh   = '0;
    addr_sel = '0;
    hash_sel = '0;
    delim_w  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (found && (winner == NUM_REQ_LOG2'(i))) begin
        win_oh[i] = 1'b1;
        addr_sel  = bus.req_addr[i*AW +: AW];
        hash_sel  = bus.req_hash_value[i*HW +: HW];
        delim_w   = bus.req_delim[i];
      end
    end
  end

  assign bus.req_ready = (rst_n && load) ? win_oh : '0;
  assign xfer          = rst_n && load && found;
  assign mask_next     = barrier_mask | win_oh;
  assign close         = xfer && delim_w && (&mask_next);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid      <= 1'b0;
      bus.out_addr       <= '0;
      bus.out_hash_value <= '0;
      bus.out_delim      <= 1'b0;
      barrier_mask       <= '0;
      rr_ptr             <= '0;
      state              <= ST_IDLE;
      grant              <= '0;
      burst_cnt          <= '0;
      burst_lim          <= 4'd1;
      last_delim         <= 1'b0;
    end else if (load) begin
      if (xfer) begin
        bus.out_valid      <= 1'b1;
        bus.out_addr       <= addr_sel;
        bus.out_hash_value <= hash_sel;
        bus.out_delim      <= close;
        last_delim         <= delim_w;
        if (hold) begin
          burst_cnt <= (burst_cnt == 5'd15) ? burst_cnt : burst_cnt + 5'd1;
        end else begin
          state     <= ST_LOCKED;
          grant     <= winner;
          burst_lim <= lim_fresh;
          burst_cnt <= 5'd1;
          if (state == ST_LOCKED) rr_ptr <= grant_next;
        end
        // The barrier-closing beat clears the mask rather than setting its bit.
        if (delim_w) barrier_mask <= close ? '0 : mask_next;
      end else begin
        bus.out_valid <= 1'b0;
        if (state == ST_LOCKED) begin
          state  <= ST_IDLE;
          rr_ptr <= grant_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_hash_pe_req_arbiter.sv
// Directed bench for hash_pe_req_arbiter: table of steady-traffic grant orders
// plus hand-written backpressure, barrier, wrap and async-reset sequences.
module tb_hash_pe_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int HW = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] cfg_max_burst;
  logic [N-1:0] barrier_mask;

  hash_pe_req_arbiter_if #(.NUM_REQ(N), .AW(AW), .HW(HW)) bus ();

  hash_pe_req_arbiter #(.NUM_REQ(N), .NUM_REQ_LOG2(2), .AW(AW), .HW(HW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_max_burst (cfg_max_burst),
    .bus           (bus.slave),
    .barrier_mask  (barrier_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cfg;
    logic [3:0]  valid;
    int          n;
    logic [63:0] seq;   // expected output source per beat, first beat in top nibble
  } vec_t;

  vec_t       vt[8];
  int         in_cnt[N];
  int         out_cnt[N];
  int         delim_at[N];
  int         stop_at[N];
  logic [3:0] valid_en;
  logic [3:0] xfer;
  logic       got;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]             = valid_en[i] && (in_cnt[i] <= stop_at[i]);
      bus.req_delim[i]             = (in_cnt[i] == delim_at[i]);
      bus.req_addr[i*AW +: AW]     = {4'(i), 12'(in_cnt[i])};
      bus.req_hash_value[i*HW +: HW] = 8'(in_cnt[i] * 3 + i);
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cycle();
    drive();
    #1;
    xfer = bus.req_valid & bus.req_ready;
    @(posedge clk);
    for (int i = 0; i < N; i++) if (xfer[i]) in_cnt[i]++;
    got = |xfer;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_cnt[i] = 0; out_cnt[i] = 0; delim_at[i] = -1; stop_at[i] = 1000;
    end
    valid_en      = '0;
    bus.out_ready = 1'b1;
    drive();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Checks source, per-source sequence number and hash of the presented beat.
  task automatic mon(input string nm, input int exp_src, input bit use_exp);
    int s;
    s = int'(bus.out_addr[15:12]);
    if (use_exp) chk({nm, "_src"}, 32'(s), 32'(exp_src));
    if (s < N) begin
      chk({nm, "_seq"}, 32'(bus.out_addr[11:0]), 32'(out_cnt[s]));
      chk({nm, "_hash"}, 32'(bus.out_hash_value), 32'(8'(out_cnt[s] * 3 + s)));
      out_cnt[s]++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nd, after, s, q, tot;
    bit seen1;

    vt[0] = '{4'd1,  4'b1111, 8,  64'h0123_0123_0000_0000};
    vt[1] = '{4'd3,  4'b0101, 8,  64'h0002_2200_0000_0000};
    vt[2] = '{4'd0,  4'b0101, 6,  64'h0202_0200_0000_0000};
    vt[3] = '{4'd2,  4'b1111, 8,  64'h0011_2233_0000_0000};
    vt[4] = '{4'd1,  4'b1010, 4,  64'h1313_0000_0000_0000};
    vt[5] = '{4'd1,  4'b1000, 3,  64'h3330_0000_0000_0000};
    vt[6] = '{4'd15, 4'b0110, 16, 64'h1111_1111_1111_1112};
    vt[7] = '{4'd4,  4'b1011, 8,  64'h0000_1111_0000_0000};

    // Reset state, with all requesters asserting valid.
    cfg_max_burst = 4'd1;
    #2;
    do_reset();
    rst_n = 1'b0;
    valid_en = 4'b1111;
    drive();
    #1;
    chk("rst_req_ready", bus.req_ready, 4'b0000);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_addr", bus.out_addr, 16'h0);
    chk("rst_out_hash", bus.out_hash_value, 8'h0);
    chk("rst_out_delim", bus.out_delim, 1'b0);
    chk("rst_mask", barrier_mask, 4'b0000);

    // Steady-traffic grant-order table.
    for (int v = 0; v < 8; v++) begin
      do_reset();
      cfg_max_burst = vt[v].cfg;
      valid_en      = vt[v].valid;
      for (int k = 0; k < vt[v].n; k++) begin
        cycle();
        chk($sformatf("v%0d_thru", v), got, 1'b1);
        chk($sformatf("v%0d_valid", v), bus.out_valid, 1'b1);
        chk($sformatf("v%0d_delim", v), bus.out_delim, 1'b0);
        mon($sformatf("v%0d_b%0d", v, k), int'(vt[v].seq[60-4*k +: 4]), 1'b1);
      end
    end

    // Backpressure: 5 stalled cycles with beat src2/seq0 held.
    do_reset();
    cfg_max_burst = 4'd1;
    valid_en = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      cycle();
      if (got) mon("bp_pre", k % 4, 1'b1);
    end
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp_req_ready", bus.req_ready, 4'b0000);
      chk("bp_valid", bus.out_valid, 1'b1);
      chk("bp_addr_held", bus.out_addr, 16'h2000);
      chk("bp_hash_held", bus.out_hash_value, 8'h02);
    end
    bus.out_ready = 1'b1;
    for (int k = 3; k < 12; k++) begin
      cycle();
      chk("bp_post_thru", got, 1'b1);
      if (got) mon("bp_post", k % 4, 1'b1);
    end
    valid_en = '0;
    cycle();
    tot = in_cnt[0] + in_cnt[1] + in_cnt[2] + in_cnt[3];
    chk("bp_beats_in", 32'(tot), 32'd12);
    chk("bp_drain_valid", bus.out_valid, 1'b0);

    // Delimiter barrier: r1 delimits at beat 2, others after 10 beats.
    do_reset();
    cfg_max_burst = 4'd1;
    valid_en = 4'b1111;
    delim_at[0] = 10; delim_at[1] = 2; delim_at[2] = 10; delim_at[3] = 10;
    stop_at[0]  = 10; stop_at[2]  = 10; stop_at[3]  = 10;
    nd = 0; after = -1; seen1 = 1'b0;
    for (int c = 0; c < 60; c++) begin
      cycle();
      if (got) begin
        s = int'(bus.out_addr[15:12]);
        q = int'(bus.out_addr[11:0]);
        if (s == 1 && q == 2) begin
          chk("bar_mask_partial", barrier_mask, 4'b0010);
          chk("bar_r1_delim_flag", bus.out_delim, 1'b0);
          seen1 = 1'b1;
        end
        if (bus.out_delim) begin
          nd++;
          chk("bar_close_src", 32'(s), 32'd3);
          chk("bar_close_seq", 32'(q), 32'd10);
          chk("bar_mask_cleared", barrier_mask, 4'b0000);
          after = c + 1;
        end
        mon("bar", 0, 1'b0);
      end
      if (seen1 && nd == 0) chk("bar_r1_stalled", bus.req_ready[1], 1'b0);
      if (c == after) begin
        chk("bar_resume_got", got, 1'b1);
        chk("bar_resume_addr", bus.out_addr, 16'h1003);
      end
    end
    chk("bar_delim_count", 32'(nd), 32'd1);
    chk("bar_seen_r1", seen1, 1'b1);

    // Wrap: only r3, then only r0, with no dead cycle between.
    do_reset();
    cfg_max_burst = 4'd1;
    valid_en = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("wrap_r3_valid", bus.out_valid, 1'b1);
      mon("wrap_r3", 3, 1'b1);
    end
    valid_en = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("wrap_r0_valid", bus.out_valid, 1'b1);
      mon("wrap_r0", 0, 1'b1);
      if (k == 0) chk("wrap_rr_ptr", dut.rr_ptr, 2'd0);
    end

    // Async reset with a partial barrier and a held output beat.
    do_reset();
    cfg_max_burst = 4'd1;
    valid_en = 4'b0110;
    delim_at[1] = 0; delim_at[2] = 0;
    stop_at[1]  = 0; stop_at[2]  = 0;
    cycle();
    cycle();
    bus.out_ready = 1'b0;
    cycle();
    chk("ar_mask_before", barrier_mask, 4'b0110);
    chk("ar_valid_before", bus.out_valid, 1'b1);
    chk("ar_addr_before", bus.out_addr, 16'h2000);
    rst_n = 1'b0;
    #1;
    chk("ar_valid_now", bus.out_valid, 1'b0);
    chk("ar_mask_now", barrier_mask, 4'b0000);
    chk("ar_delim_now", bus.out_delim, 1'b0);
    valid_en = 4'b1111;
    for (int i = 0; i < N; i++) stop_at[i] = 1000;
    bus.out_ready = 1'b1;
    drive();
    #1;
    chk("ar_req_ready", bus.req_ready, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
